calc_serial_front: RTL

// - Serial command front end for the calculator ALU; replaces the file-driven stimulus/capture path with hardware.
// - Shifts in a 10-bit command word {ctrl[1:0], i1[3:0], i2[3:0]}, MSB first, and drives it onto the ALU inputs.
// - Waits a fixed settle time, then captures the 7-bit ALU result and shifts it out serially, MSB first.
// - Sits between an external bit-serial link and the combinational ALU.

---
 rtl/calc_serial_front.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/calc_serial_front.sv
// calc_serial_front: bit-serial command front end for the calculator ALU.
// Optional build macro CALC_PARITY_EN appends an even-parity bit to every command frame.
module calc_serial_front #(
    parameter int CMD_W      = 10,
    parameter int RES_W      = 7,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             busy,
    output logic [1:0]       alu_ctrl,
    output logic [3:0]       alu_i1,
    output logic [3:0]       alu_i2,
    input  logic [RES_W-1:0] alu_o,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic             parity_err
);

`ifdef CALC_PARITY_EN
    localparam int FRAME_W = CMD_W + 1;
`else
    localparam int FRAME_W = CMD_W;
`endif

    // One counter serves shift-in, settle and shift-out, so size it for the longest phase.
    localparam int CNT_MAX = (FRAME_W > RES_W)
                           ? ((FRAME_W > SETTLE_CYC) ? FRAME_W : SETTLE_CYC)
                           : ((RES_W > SETTLE_CYC) ? RES_W : SETTLE_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        DRIVE,
        CAPTURE,
        SHIFT_OUT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] cmd;
    logic [RES_W-1:0]   res;
    logic [FRAME_W-1:0] frame_next;
    logic [CMD_W-1:0]   cmd_field;

    assign frame_next = {cmd[FRAME_W-2:0], sin};
    assign cmd_field  = frame_next[FRAME_W-1 -: CMD_W];

`ifdef CALC_PARITY_EN
    logic frame_ok;
    assign frame_ok = ~^frame_next;
`else
    assign parity_err = 1'b0;
`endif

    // NOTE: every register here is written with <= so that all state updates on an edge
    // see the pre-edge values; reset is sampled on the clock edge like any other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cmd        <= '0;
            res        <= '0;
            busy       <= 1'b0;
            alu_ctrl   <= '0;
            alu_i1     <= '0;
            alu_i2     <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
`ifdef CALC_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef CALC_PARITY_EN
            parity_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (sin_valid) begin
                        cmd   <= frame_next;
                        cnt   <= CNT_W'(1);
                        state <= SHIFT_IN;
                    end
                end

                SHIFT_IN: begin
                    if (sin_valid) begin
                        cmd <= frame_next;
                        if (cnt == CNT_W'(FRAME_W - 1)) begin
                            cnt <= '0;
`ifdef CALC_PARITY_EN
                            if (!frame_ok) begin
                                parity_err <= 1'b1;
                                state      <= IDLE;
                            end else
`endif
                            begin
                                // The ALU only ever sees a complete, accepted frame.
                                alu_ctrl <= cmd_field[CMD_W-1 -: 2];
                                alu_i1   <= cmd_field[CMD_W-3 -: 4];
                                alu_i2   <= cmd_field[CMD_W-7 -: 4];
                                busy     <= 1'b1;
                                state    <= DRIVE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                DRIVE: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        cnt   <= '0;
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                CAPTURE: begin
                    // The MSB goes straight to sout; res keeps the bits still to be sent.
                    sout       <= alu_o[RES_W-1];
                    sout_valid <= 1'b1;
                    res        <= {alu_o[RES_W-2:0], 1'b0};
                    cnt        <= '0;
                    state      <= SHIFT_OUT;
                end

                SHIFT_OUT: begin
                    if (cnt == CNT_W'(RES_W - 1)) begin
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        busy       <= 1'b0;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else begin
                        sout <= res[RES_W-1];
                        res  <= res << 1;
                        cnt  <= cnt + CNT_W'(1);
                        done <= (cnt == CNT_W'(RES_W - 2));
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
